// File: rtl/param_ram.sv
// Single-port word RAM with registered 1-cycle reads and a zeroing sweep
// that runs after reset and on every clear request.
module param_ram #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    input  logic              clear,
    output logic [DATA_W-1:0] ram_out,
    output logic              rd_valid,
    output logic              busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] w_clr_cnt_nxt;
    logic [DATA_W-1:0] r_ram_out;
    logic [DATA_W-1:0] w_ram_out_nxt;
    logic              r_rd_valid;
    logic              w_rd_valid_nxt;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_sweep_last;

    logic [DATA_W-1:0] r_mem [DEPTH];

    assign w_sweep_last = (r_clr_cnt == ADDR_W'(DEPTH - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SWEEP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SWEEP: if (w_sweep_last) w_state_nxt = IDLE;
            IDLE:  if (clear)        w_state_nxt = SWEEP;
            default:                 w_state_nxt = SWEEP;
        endcase
    end

    // Datapath controls: sweep writes zeros, IDLE serves load/read (write-first)
    always_comb begin
        w_clr_cnt_nxt  = r_clr_cnt;
        w_ram_out_nxt  = r_ram_out;
        w_rd_valid_nxt = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_addr     = address;
        w_mem_wdata    = data_in;
        case (r_state)
            SWEEP: begin
                w_mem_we      = 1'b1;
                w_mem_addr    = r_clr_cnt;
                w_mem_wdata   = '0;
                w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
            end
            IDLE: begin
                if (clear) begin
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_mem_we = load;
                    if (rd_en) begin
                        w_rd_valid_nxt = 1'b1;
                        w_ram_out_nxt  = load ? data_in : r_mem[address];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clr_cnt  <= '0;
            r_ram_out  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_clr_cnt  <= w_clr_cnt_nxt;
            r_ram_out  <= w_ram_out_nxt;
            r_rd_valid <= w_rd_valid_nxt;
        end
    end

    // Array has no reset; contents are zeroed only by the sweep
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    assign ram_out  = r_ram_out;
    assign rd_valid = r_rd_valid;
    assign busy     = (r_state == SWEEP);

endmodule

// File: tb/tb_param_ram.sv
// Directed bench for param_ram at ADDR_W=3, DATA_W=16.
module tb_param_ram;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              load = 1'b0;
    logic [ADDR_W-1:0] address = '0;
    logic [DATA_W-1:0] data_in = '0;
    logic              rd_en = 1'b0;
    logic              clear = 1'b0;
    logic [DATA_W-1:0] ram_out;
    logic              rd_valid;
    logic              busy;

    int n_checks = 0;
    int n_pass   = 0;

    param_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .address  (address),
        .data_in  (data_in),
        .rd_en    (rd_en),
        .clear    (clear),
        .ram_out  (ram_out),
        .rd_valid (rd_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until busy drops, bounded at 20
    task automatic count_busy(output int cnt, output int rv_seen);
        cnt = 0;
        rv_seen = 0;
        while (busy && cnt < 20) begin
            step();
            cnt++;
            if (rd_valid) rv_seen++;
        end
    endtask

    task automatic write_word(input int a, input logic [DATA_W-1:0] d);
        load = 1'b1; address = ADDR_W'(a); data_in = d;
        step();
        load = 1'b0;
    endtask

    initial begin
        int cnt;
        int rv;

        #2 reset = 1'b1;
        step();
        check("rst_ram_out", 32'(ram_out), 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h1);
        step();
        reset = 1'b0;

        count_busy(cnt, rv);
        check("init_sweep_len", 32'(cnt), 32'd8);

        // Every word reads back zero, back to back
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1; address = ADDR_W'(i);
            step();
            check($sformatf("init_rv_%0d", i), 32'(rd_valid), 32'h1);
            check($sformatf("init_rd_%0d", i), 32'(ram_out), 32'h0);
        end
        rd_en = 1'b0;
        step();
        check("init_rv_drop", 32'(rd_valid), 32'h0);

        write_word(5, 16'hBEEF);
        check("wr_no_rv", 32'(rd_valid), 32'h0);
        rd_en = 1'b1; address = 3'd5;
        step();
        rd_en = 1'b0;
        check("rd5_data", 32'(ram_out), 32'hBEEF);
        check("rd5_rv", 32'(rd_valid), 32'h1);
        step();
        check("rd5_rv_pulse", 32'(rd_valid), 32'h0);
        check("rd5_hold", 32'(ram_out), 32'hBEEF);

        load = 1'b1; rd_en = 1'b1; address = 3'd2; data_in = 16'h1234;
        step();
        load = 1'b0; rd_en = 1'b0;
        check("wfirst_data", 32'(ram_out), 32'h1234);
        check("wfirst_rv", 32'(rd_valid), 32'h1);
        rd_en = 1'b1; address = 3'd2;
        step();
        rd_en = 1'b0;
        check("wfirst_stored", 32'(ram_out), 32'h1234);

        for (int i = 0; i < 8; i++) write_word(i, 16'(16'h00A0 + i));
        rd_en = 1'b1; address = 3'd3;
        step();
        rd_en = 1'b0;
        check("fill_rd3", 32'(ram_out), 32'h00A3);

        // Clear with load/rd_en/clear hammered during the sweep
        clear = 1'b1;
        step();
        check("clr_busy", 32'(busy), 32'h1);
        load = 1'b1; address = 3'd0; data_in = 16'hFFFF; rd_en = 1'b1;
        count_busy(cnt, rv);
        load = 1'b0; rd_en = 1'b0; clear = 1'b0;
        check("clr_sweep_len", 32'(cnt), 32'd8);
        check("clr_rv_quiet", 32'(rv), 32'd0);
        check("clr_hold_out", 32'(ram_out), 32'h00A3);
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1; address = ADDR_W'(i);
            step();
            check($sformatf("clr_rd_%0d", i), 32'(ram_out), 32'h0);
        end
        rd_en = 1'b0;
        step();

        for (int i = 1; i <= 4; i++) write_word(i, 16'(16'h11 * i));
        for (int i = 1; i <= 4; i++) begin
            rd_en = 1'b1; address = ADDR_W'(i);
            step();
            check($sformatf("b2b_rv_%0d", i), 32'(rd_valid), 32'h1);
            check($sformatf("b2b_rd_%0d", i), 32'(ram_out), 32'(16'h11 * i));
        end
        rd_en = 1'b0;
        step();
        check("b2b_rv_drop", 32'(rd_valid), 32'h0);
        check("b2b_hold", 32'(ram_out), 32'h44);

        // Reset mid-sweep restarts the full sweep
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("mid_busy", 32'(busy), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_out", 32'(ram_out), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h1);
        step();
        reset = 1'b0;
        count_busy(cnt, rv);
        check("mid_sweep_len", 32'(cnt), 32'd8);
        rd_en = 1'b1; address = 3'd4;
        step();
        rd_en = 1'b0;
        check("mid_rd4", 32'(ram_out), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/param_ram.md
PARAM_RAM -- requirements
Module: param_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 16, word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 14, address width in bits; depth DEPTH = 2**ADDR_W words.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port load, input, 1, write enable.
REQ-006 SHALL have port address, input, ADDR_W, word address for both read and write.
REQ-007 SHALL have port data_in, input, DATA_W, write data.
REQ-008 SHALL have port rd_en, input, 1, read request.
REQ-009 SHALL have port clear, input, 1, request to zero the whole array.
REQ-010 SHALL have port ram_out, output, DATA_W, registered read data.
REQ-011 SHALL have port rd_valid, output, 1, one-cycle pulse marking new ram_out.
REQ-012 SHALL have port busy, output, 1, high while a clear sweep runs.

Function
REQ-013 SHALL implement a two-state FSM: SWEEP and IDLE.
REQ-014 SHALL, in SWEEP, write zero to mem[clr_cnt] on each edge, then increment the ADDR_W-bit clr_cnt.
REQ-015 SHALL leave SWEEP for IDLE on the edge that writes clr_cnt == DEPTH-1, with busy falling on that same edge.
REQ-016 SHALL hold busy = 1 exactly while the state is SWEEP.
REQ-017 SHALL ignore load, rd_en and clear while in SWEEP: no array write from data_in, rd_valid held 0, sweep not restarted.
REQ-018 SHALL, in IDLE with clear = 1, enter SWEEP at the next edge with clr_cnt = 0.
- load and rd_en in that same cycle are ignored.
REQ-019 SHALL, in IDLE with load = 1 and clear = 0, write data_in to mem[address] at the edge.
REQ-020 SHALL, in IDLE with rd_en = 1 and clear = 0, load ram_out with mem[address] at the edge and pulse rd_valid high for that one cycle.
- Read latency is 1 cycle.
REQ-021 SHALL be write-first: with load and rd_en both 1 to the same address, ram_out takes data_in.
REQ-022 SHALL hold ram_out unchanged when no read completes; rd_valid = 0 in those cycles.
REQ-023 SHALL support back-to-back reads: rd_en high N consecutive IDLE cycles gives N consecutive rd_valid pulses.
REQ-024 SHALL treat every address as valid; there is no out-of-range case.

Reset
REQ-025 SHALL, while reset = 1 and independent of clk, set ram_out = 0, rd_valid = 0, busy = 1, state = SWEEP, clr_cnt = 0.
REQ-026 SHALL, after reset deassertion, run a full sweep.
- busy falls after DEPTH rising edges.
- The array is all-zero when busy falls.
REQ-027 SHALL restart the sweep from clr_cnt = 0 if reset asserts mid-sweep.
REQ-028 SHALL not rely on reset to clear the array; zeroing is done only by the sweep.

Verification
REQ-029 ADDR_W=3, DATA_W=16; release reset -> busy = 1 for exactly 8 edges then 0; reads of addresses 0..7 return 0x0000, each with rd_valid one cycle after rd_en.
REQ-030 IDLE: write 0xBEEF to addr 5, then read addr 5 -> ram_out = 0xBEEF, rd_valid = 1 for one cycle only; ram_out holds 0xBEEF afterwards.
REQ-031 IDLE: load = 1, rd_en = 1, address = 2, data_in = 0x1234, old mem[2] = 0x0000 -> next cycle ram_out = 0x1234.
REQ-032 Fill addresses 0..7 with 0x00A0+i, pulse clear -> busy = 1 for 8 cycles.
- load asserted during the sweep has no effect.
- All reads afterwards return 0x0000.
REQ-033 Assert reset at sweep cycle 4 -> ram_out = 0 and busy = 1 immediately; after release busy lasts a full 8 edges.
REQ-034 rd_en held high 4 cycles in IDLE over addresses 1,2,3,4 holding 0x11,0x22,0x33,0x44 -> rd_valid high 4 consecutive cycles with that data in order.
